if_id_queue: RTL and testbench

- Instruction fetch queue between the PC/instruction-memory fetch stage and the decode stage.
- Buffers {pc, instr} pairs from fetch with valid/ready handshakes on both sides, so decode back-pressure does not drop fetched instructions.
- Discards all buffered entries on a control-flow redirect (jump/branch flush).

---
 rtl/if_id_queue_pkg.sv | 14 +
 rtl/if_id_queue_if.sv | 28 ++
 rtl/if_id_queue_ptr.sv | 29 ++
 rtl/if_id_queue.sv | 108 ++++++++++
 tb/tb_if_id_queue.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/if_id_queue_pkg.sv
// Shared defaults for the fetch/decode instruction queue.
// Optional zero-latency pass-through is enabled by defining IFQ_BYPASS_EN.
package if_id_queue_pkg;

  localparam int          IFQ_XLEN  = 32;
  localparam int          IFQ_DEPTH = 4;
  // Bubble encoding (addi x0,x0,0) decode substitutes while out_valid is low.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic int ifq_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-side and decode-side handshake bundle for if_id_queue.
// The queue takes the slave view; the driving environment takes the master view.
interface if_id_queue_if
  import if_id_queue_pkg::*;
#(
  parameter int XLEN = IFQ_XLEN
);

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr
  );

  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr
  );

endinterface

// File: rtl/if_id_queue_ptr.sv
// Wrapping circular-buffer pointer with increment enable and synchronous clear.
// Wraps by natural overflow, so the buffer depth must be a power of two.
module ifq_ptr
  import if_id_queue_pkg::*;
#(
  parameter int W = $clog2(IFQ_DEPTH)
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/if_id_queue.sv
// Instruction fetch queue between fetch and decode: FIFO of {pc, instr} with flush.
// Define IFQ_BYPASS_EN for same-cycle pass-through when the queue is empty.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int XLEN  = IFQ_XLEN
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  if_id_queue_if.slave           bus,
  output logic [$clog2(DEPTH):0] count
);

  localparam int             AW       = $clog2(DEPTH);
  localparam int             CW       = ifq_cnt_w(DEPTH);
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [XLEN-1:0] instr_mem_q [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          full;
  logic          empty;
  logic          bypass;
  logic          push;
  logic          pop;
  logic          clr;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign clr   = reset | flush;

`ifdef IFQ_BYPASS_EN
  // Empty queue with a ready consumer: hand the fetch entry straight to decode.
  assign bypass = empty & bus.in_valid & bus.out_ready & ~flush;
`else
  assign bypass = 1'b0;
`endif

  // Full blocks pushes even if decode pops this cycle (no pop-through).
  assign push = bus.in_valid & ~full & ~flush & ~bypass;
  assign pop  = ~empty & bus.out_ready & ~flush;

  assign bus.in_ready  = ~full;
  assign bus.out_valid = (~empty | bypass) & ~flush;
  assign count         = count_q;

  // Head mux reads zero when empty so outputs are clean straight out of reset.
  always_comb begin
    bus.out_pc    = '0;
    bus.out_instr = '0;
    if (bypass) begin
      bus.out_pc    = bus.in_pc;
      bus.out_instr = bus.in_instr;
    end else if (!empty) begin
      bus.out_pc    = pc_mem_q[rd_ptr];
      bus.out_instr = instr_mem_q[rd_ptr];
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) count_q <= '0;
    else     count_q <= count_d;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr]    <= bus.in_pc;
      instr_mem_q[wr_ptr] <= bus.in_instr;
    end
  end

  ifq_ptr #(.W(AW)) u_rd_ptr (
    .clk   (clk),
    .clr_i (clr),
    .inc_i (pop),
    .ptr_o (rd_ptr)
  );

  ifq_ptr #(.W(AW)) u_wr_ptr (
    .clk   (clk),
    .clr_i (clr),
    .inc_i (push),
    .ptr_o (wr_ptr)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (count_q <= FULL_CNT);
      assert (!(pop && empty));
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: a reference queue predicts handshakes, count and head.
// Build with IFQ_BYPASS_EN defined to exercise the same-cycle pass-through model.
module tb_if_id_queue;
  import if_id_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   flush;
  logic [$clog2(DEPTH):0] count;

  if_id_queue_if #(.XLEN(XLEN)) bus ();

  if_id_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus),
    .count (count)
  );

  always #5 clk = ~clk;

  ent_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hA0 + (pc >> 2);
  endfunction

  // Drive one cycle, check outputs at the falling edge, then advance the model at the rising edge.
  task automatic cycle(input bit rst, input bit fl, input bit iv, input logic [31:0] pc, input bit ordy);
    ent_t e;
    bit   exp_ready, exp_valid, byp, push, pop;
    reset         = rst;
    flush         = fl;
    bus.in_valid  = iv;
    bus.in_pc     = pc;
    bus.in_instr  = instr_of(pc);
    bus.out_ready = ordy;
    @(negedge clk);
    if (rst) begin
      sb.delete();
    end else begin
      byp       = BYP && sb.size() == 0 && iv && ordy && !fl;
      exp_ready = sb.size() < DEPTH;
      exp_valid = !fl && (sb.size() != 0 || byp);
      check("count", 64'(count), 64'(sb.size()));
      check("in_ready", 64'(bus.in_ready), 64'(exp_ready));
      check("out_valid", 64'(bus.out_valid), 64'(exp_valid));
      if (exp_valid) begin
        if (byp) e = '{pc: pc, instr: instr_of(pc)};
        else     e = sb[0];
        check("out_pc", 64'(bus.out_pc), 64'(e.pc));
        check("out_instr", 64'(bus.out_instr), 64'(e.instr));
      end
      push = iv && exp_ready && !fl && !byp;
      pop  = sb.size() != 0 && ordy && !fl;
      if (fl) begin
        sb.delete();
      end else begin
        if (pop)  void'(sb.pop_front());
        if (push) sb.push_back('{pc: pc, instr: instr_of(pc)});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, ordy);
  endtask

  initial begin
    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b0;

    // Reset then idle
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(1, 1'b0);
    check("reset_out_pc", 64'(bus.out_pc), 64'h0);
    check("reset_count", 64'(count), 64'h0);

    // Fill to full with decode stalled, hold an extra entry, then drain
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 32'(4 * i), 1'b0);
    check("full_count", 64'(count), 64'd4);
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 32'h10, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h10, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 32'h10, 1'b1);
    idle(6, 1'b1);

    // Simultaneous push/pop at count 2
    cycle(1'b0, 1'b0, 1'b1, 32'h18, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h1C, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h20, 1'b1);
    check("pushpop_count", 64'(count), 64'd2);
    idle(4, 1'b1);

    // Flush at count 3 with a push in flight, then a fresh push
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 32'h34 + 32'(4 * i), 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 32'h40, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
    idle(3, 1'b1);

    // Wrap-around at steady one-in/one-out
    cycle(1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    for (int i = 1; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, 32'(4 * i), 1'b1);
    check("wrap_count", 64'(count), 64'd1);
    idle(2, 1'b1);

    // Empty queue with a ready consumer (pass-through when enabled)
    cycle(1'b0, 1'b0, 1'b1, 32'h200, 1'b1);
    idle(2, 1'b1);

    // Reset together with flush mid-operation
    cycle(1'b0, 1'b0, 1'b1, 32'h300, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h304, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'h308, 1'b1);
    idle(1, 1'b0);
    check("rstflush_out_pc", 64'(bus.out_pc), 64'h0);

    // Random traffic with occasional flushes
    for (int i = 0; i < 60; i++)
      cycle(1'b0, $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
            32'h1000 + 32'(4 * i), $urandom_range(0, 2) != 0);
    idle(6, 1'b1);
    check("final_empty", 64'(count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
